// File: rtl/payload_fifo_pkg.sv
// Shared constants and width helpers for the packet-commit payload FIFO.
package payload_fifo_pkg;

  // Entries in the registered output stage behind the RAM read port.
  localparam int unsigned OSTAGE_DEPTH = 2;

  // Address width for a power-of-two storage depth.
  function automatic int unsigned addr_w(input int unsigned depth);
    return $clog2(depth);
  endfunction

  // Pointer/count width: one extra bit to tell full from empty.
  function automatic int unsigned ptr_w(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/payload_fifo_ram.sv
// Simple dual-port storage array, one write port and one registered read port.
// The array itself has no reset; the read register holds when not enabled.
module payload_fifo_ram
  import payload_fifo_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 1024
) (
  input  logic                       clk,
  input  logic                       we,
  input  logic [addr_w(DEPTH)-1:0]   waddr,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       re,
  input  logic [addr_w(DEPTH)-1:0]   raddr,
  output logic [WIDTH-1:0]           rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Write port.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Registered read port, one cycle of latency.
  always_ff @(posedge clk) begin
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/payload_packet_fifo.sv
// FWFT payload FIFO with packet commit (EOP) and abort on the write side.
// Words are readable only once their packet is committed.
// Optional macro PAYLOAD_FIFO_ERR_FLAGS_EN adds sticky OVERFLOW/UNDERFLOW outputs.
module payload_packet_fifo
  import payload_fifo_pkg::*;
#(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned DEPTH      = 1024,
  parameter int unsigned AFULL_VAL  = 1020,
  parameter int unsigned AEMPTY_VAL = 4
) (
  input  logic                      CLK,
  input  logic                      RESET,
  input  logic [WIDTH-1:0]          DATA,
  input  logic                      WE,
  input  logic                      EOP,
  input  logic                      ABORT,
  input  logic                      RE,
  output logic [WIDTH-1:0]          Q,
  output logic                      DVLD,
  output logic                      EMPTY,
  output logic                      FULL,
  output logic                      AFULL,
  output logic                      AEMPTY,
`ifdef PAYLOAD_FIFO_ERR_FLAGS_EN
  output logic                      OVERFLOW,
  output logic                      UNDERFLOW,
`endif
  output logic [ptr_w(DEPTH)-1:0]   WRCNT,
  output logic [ptr_w(DEPTH)-1:0]   RDCNT
);

  localparam int unsigned AW = addr_w(DEPTH);
  localparam int unsigned PW = ptr_w(DEPTH);
  localparam logic [PW-1:0] PTR_ONE    = PW'(1);
  localparam logic [PW-1:0] DEPTH_CNT  = PW'(DEPTH);
  localparam logic [PW-1:0] AFULL_CNT  = PW'(AFULL_VAL);
  localparam logic [PW-1:0] AEMPTY_CNT = PW'(AEMPTY_VAL);
  localparam logic [2:0]    OST_LIM    = 3'(OSTAGE_DEPTH);

  // wr_ptr: speculative write; cmt_ptr: end of committed data;
  // rd_ptr: words popped by the consumer; fetch_ptr: next RAM word to read.
  logic [PW-1:0]    wr_ptr, cmt_ptr, rd_ptr, fetch_ptr;
  logic [PW-1:0]    wr_cnt, rd_cnt;
  logic             full, accept, ram_we, commit, pop, fetch;
  logic             rd_valid;
  logic [2:0]       occ;
  logic [WIDTH-1:0] ram_q;
  logic [WIDTH-1:0] ostage [OSTAGE_DEPTH];
  logic [1:0]       ostage_cnt;

  payload_fifo_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk   (CLK),
    .we    (ram_we),
    .waddr (wr_ptr[AW-1:0]),
    .wdata (DATA),
    .re    (fetch),
    .raddr (fetch_ptr[AW-1:0]),
    .rdata (ram_q)
  );

  // Accept/commit/pop qualifiers and RAM prefetch decision.
  always_comb begin
    wr_cnt = wr_ptr - rd_ptr;
    rd_cnt = cmt_ptr - rd_ptr;
    full   = (wr_cnt == DEPTH_CNT);
    accept = WE && !full;
    ram_we = accept && !ABORT;
    commit = ram_we && EOP;
    pop    = RE && (ostage_cnt != 2'd0);
    // Counting this cycle's pop as freed space lets the prefetch keep one
    // word in flight per cycle, so back-to-back reads see no bubbles.
    occ    = {1'b0, ostage_cnt} + {2'b00, rd_valid} - {2'b00, pop};
    fetch  = (fetch_ptr != cmt_ptr) && (occ < OST_LIM);
  end

  // Status outputs derived from the registered pointers and output stage.
  always_comb begin
    WRCNT  = wr_cnt;
    RDCNT  = rd_cnt;
    FULL   = full;
    AFULL  = (wr_cnt >= AFULL_CNT);
    AEMPTY = (rd_cnt <= AEMPTY_CNT);
    DVLD   = (ostage_cnt != 2'd0);
    EMPTY  = (ostage_cnt == 2'd0);
    Q      = ostage[0];
  end

  // Pointer updates; abort rewinds the speculative pointer and beats commit.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      wr_ptr    <= '0;
      cmt_ptr   <= '0;
      rd_ptr    <= '0;
      fetch_ptr <= '0;
      rd_valid  <= 1'b0;
    end else begin
      if (ABORT)       wr_ptr <= cmt_ptr;
      else if (accept) wr_ptr <= wr_ptr + PTR_ONE;
      if (commit)      cmt_ptr   <= wr_ptr + PTR_ONE;
      if (pop)         rd_ptr    <= rd_ptr + PTR_ONE;
      if (fetch)       fetch_ptr <= fetch_ptr + PTR_ONE;
      rd_valid <= fetch;
    end
  end

  // Two-entry output stage; entry 0 is the head presented on Q.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int unsigned i = 0; i < OSTAGE_DEPTH; i++) ostage[i] <= '0;
      ostage_cnt <= 2'd0;
    end else begin
      case ({rd_valid, pop})
        2'b10: begin
          if (ostage_cnt == 2'd0) ostage[0] <= ram_q;
          else                    ostage[1] <= ram_q;
          ostage_cnt <= ostage_cnt + 2'd1;
        end
        2'b01: begin
          ostage[0]  <= ostage[1];
          ostage_cnt <= ostage_cnt - 2'd1;
        end
        2'b11: begin
          if (ostage_cnt == 2'd1) begin
            ostage[0] <= ram_q;
          end else begin
            ostage[0] <= ostage[1];
            ostage[1] <= ram_q;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef PAYLOAD_FIFO_ERR_FLAGS_EN
  // Sticky illegal-access flags, cleared only by reset.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      OVERFLOW  <= 1'b0;
      UNDERFLOW <= 1'b0;
    end else begin
      if (WE && full)                    OVERFLOW  <= 1'b1;
      if (RE && (ostage_cnt == 2'd0))    UNDERFLOW <= 1'b1;
    end
  end
`else
  // No status kept: the accept and pop qualifiers already drop illegal accesses.
`endif

endmodule

// File: tb/tb_payload_packet_fifo.sv
// Directed self-checking bench for payload_packet_fifo (DEPTH=16).
module tb_payload_packet_fifo;

  logic       clk = 1'b0;
  logic       reset, we, eop, abort, re;
  logic [7:0] data, q;
  logic       dvld, empty, full, afull, aempty;
  logic [4:0] wrcnt, rdcnt;
`ifdef PAYLOAD_FIFO_ERR_FLAGS_EN
  logic       overflow, underflow;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  payload_packet_fifo #(
    .WIDTH      (8),
    .DEPTH      (16),
    .AFULL_VAL  (14),
    .AEMPTY_VAL (2)
  ) dut (
    .CLK    (clk),
    .RESET  (reset),
    .DATA   (data),
    .WE     (we),
    .EOP    (eop),
    .ABORT  (abort),
    .RE     (re),
    .Q      (q),
    .DVLD   (dvld),
    .EMPTY  (empty),
    .FULL   (full),
    .AFULL  (afull),
    .AEMPTY (aempty),
`ifdef PAYLOAD_FIFO_ERR_FLAGS_EN
    .OVERFLOW  (overflow),
    .UNDERFLOW (underflow),
`endif
    .WRCNT  (wrcnt),
    .RDCNT  (rdcnt)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    we = 1'b0; eop = 1'b0; abort = 1'b0; re = 1'b0; data = 8'h00;
  endtask

  task automatic test_reset();
    idle(); reset = 1'b1; step(); step();
    total++; if (dvld !== 1'b0)   begin bad++; $display("FAIL rst_dvld got=%b want=0", dvld); end
    total++; if (empty !== 1'b1)  begin bad++; $display("FAIL rst_empty got=%b want=1", empty); end
    total++; if (full !== 1'b0)   begin bad++; $display("FAIL rst_full got=%b want=0", full); end
    total++; if (afull !== 1'b0)  begin bad++; $display("FAIL rst_afull got=%b want=0", afull); end
    total++; if (aempty !== 1'b1) begin bad++; $display("FAIL rst_aempty got=%b want=1", aempty); end
    total++; if (wrcnt !== 5'd0)  begin bad++; $display("FAIL rst_wrcnt got=%0d want=0", wrcnt); end
    total++; if (rdcnt !== 5'd0)  begin bad++; $display("FAIL rst_rdcnt got=%0d want=0", rdcnt); end
    total++; if (q !== 8'h00)     begin bad++; $display("FAIL rst_q got=%h want=00", q); end
    reset = 1'b0;
  endtask

  task automatic test_commit();
    idle(); we = 1'b1; data = 8'h11; step(); data = 8'h22; step();
    total++; if (wrcnt !== 5'd2) begin bad++; $display("FAIL c_open_wrcnt got=%0d want=2", wrcnt); end
    total++; if (rdcnt !== 5'd0) begin bad++; $display("FAIL c_open_rdcnt got=%0d want=0", rdcnt); end
    data = 8'h33; eop = 1'b1; step();
    total++; if (rdcnt !== 5'd3) begin bad++; $display("FAIL c_eop_rdcnt got=%0d want=3", rdcnt); end
    total++; if (wrcnt !== 5'd3) begin bad++; $display("FAIL c_eop_wrcnt got=%0d want=3", wrcnt); end
    total++; if (dvld !== 1'b0)  begin bad++; $display("FAIL c_n0_dvld got=%b want=0", dvld); end
    idle(); step();
    total++; if (dvld !== 1'b0)  begin bad++; $display("FAIL c_n1_dvld got=%b want=0", dvld); end
    step();
    total++; if (dvld !== 1'b1)  begin bad++; $display("FAIL c_n2_dvld got=%b want=1", dvld); end
    total++; if (q !== 8'h11)    begin bad++; $display("FAIL c_n2_q got=%h want=11", q); end
    re = 1'b1; step();
    total++; if (q !== 8'h22)    begin bad++; $display("FAIL c_pop1_q got=%h want=22", q); end
    total++; if (rdcnt !== 5'd2) begin bad++; $display("FAIL c_pop1_rdcnt got=%0d want=2", rdcnt); end
    step();
    total++; if (q !== 8'h33)    begin bad++; $display("FAIL c_pop2_q got=%h want=33", q); end
    step();
    total++; if (empty !== 1'b1) begin bad++; $display("FAIL c_drain_empty got=%b want=1", empty); end
    total++; if (wrcnt !== 5'd0) begin bad++; $display("FAIL c_drain_wrcnt got=%0d want=0", wrcnt); end
    idle();
  endtask

  task automatic test_abort();
    idle(); we = 1'b1;
    for (int i = 0; i < 5; i++) begin
      data = 8'hB0 + 8'(i); step();
      total++; if (wrcnt !== 5'(i + 1)) begin bad++; $display("FAIL a_wrcnt[%0d] got=%0d want=%0d", i, wrcnt, i + 1); end
      total++; if (rdcnt !== 5'd0)      begin bad++; $display("FAIL a_rdcnt[%0d] got=%0d want=0", i, rdcnt); end
      total++; if (dvld !== 1'b0)       begin bad++; $display("FAIL a_dvld[%0d] got=%b want=0", i, dvld); end
    end
    we = 1'b0; abort = 1'b1; step();
    total++; if (wrcnt !== 5'd0) begin bad++; $display("FAIL a_post_wrcnt got=%0d want=0", wrcnt); end
    total++; if (rdcnt !== 5'd0) begin bad++; $display("FAIL a_post_rdcnt got=%0d want=0", rdcnt); end
    idle(); step(); step(); step();
    total++; if (dvld !== 1'b0)  begin bad++; $display("FAIL a_late_dvld got=%b want=0", dvld); end
  endtask

  task automatic test_full();
    logic exp_af, exp_full;
    idle(); we = 1'b1;
    for (int i = 0; i < 16; i++) begin
      data = 8'hA0 + 8'(i); eop = (i == 15); step();
      exp_af = (i + 1 >= 14); exp_full = (i + 1 == 16);
      total++; if (afull !== exp_af)  begin bad++; $display("FAIL f_afull[%0d] got=%b want=%b", i, afull, exp_af); end
      total++; if (full !== exp_full) begin bad++; $display("FAIL f_full[%0d] got=%b want=%b", i, full, exp_full); end
    end
    total++; if (rdcnt !== 5'd16) begin bad++; $display("FAIL f_rdcnt got=%0d want=16", rdcnt); end
    data = 8'hEE; eop = 1'b1; step();
    total++; if (wrcnt !== 5'd16) begin bad++; $display("FAIL f_drop_wrcnt got=%0d want=16", wrcnt); end
    total++; if (rdcnt !== 5'd16) begin bad++; $display("FAIL f_drop_rdcnt got=%0d want=16", rdcnt); end
    idle(); step(); step();
    re = 1'b1;
    for (int i = 0; i < 16; i++) begin
      total++; if (dvld !== 1'b1) begin bad++; $display("FAIL f_rd_dvld[%0d] got=%b want=1", i, dvld); end
      total++; if (q !== 8'hA0 + 8'(i)) begin bad++; $display("FAIL f_rd_q[%0d] got=%h want=%h", i, q, 8'hA0 + 8'(i)); end
      exp_af = (16 - i <= 2);
      total++; if (aempty !== exp_af) begin bad++; $display("FAIL f_aempty[%0d] got=%b want=%b", i, aempty, exp_af); end
      step();
    end
    total++; if (empty !== 1'b1)  begin bad++; $display("FAIL f_end_empty got=%b want=1", empty); end
    total++; if (aempty !== 1'b1) begin bad++; $display("FAIL f_end_aempty got=%b want=1", aempty); end
    total++; if (wrcnt !== 5'd0)  begin bad++; $display("FAIL f_end_wrcnt got=%0d want=0", wrcnt); end
    idle();
  endtask

  task automatic test_back_to_back();
    int exp_next;
    exp_next = 0;
    idle(); re = 1'b1;
    for (int i = 0; i < 48; i++) begin
      we = 1'b1; eop = 1'b1; data = 8'(i); step();
      total++; if (wrcnt > 5'd3) begin bad++; $display("FAIL s_wrcnt[%0d] got=%0d want<=3", i, wrcnt); end
      if (i >= 2) begin
        total++; if (dvld !== 1'b1) begin bad++; $display("FAIL s_bubble[%0d] got=%b want=1", i, dvld); end
      end
      if (dvld === 1'b1) begin
        total++; if (q !== 8'(exp_next)) begin bad++; $display("FAIL s_q[%0d] got=%h want=%h", i, q, 8'(exp_next)); end
        exp_next++;
      end
    end
    we = 1'b0; eop = 1'b0;
    for (int k = 0; k < 8; k++) begin
      step();
      if (dvld === 1'b1) begin
        total++; if (q !== 8'(exp_next)) begin bad++; $display("FAIL s_tail_q[%0d] got=%h want=%h", k, q, 8'(exp_next)); end
        exp_next++;
      end
    end
    total++; if (exp_next != 48) begin bad++; $display("FAIL s_count got=%0d want=48", exp_next); end
    total++; if (empty !== 1'b1) begin bad++; $display("FAIL s_empty got=%b want=1", empty); end
    idle();
  endtask

  task automatic test_same_cycle();
    idle(); we = 1'b1; eop = 1'b1; data = 8'h55; step();
    eop = 1'b0; data = 8'h66; step();
    total++; if (wrcnt !== 5'd2) begin bad++; $display("FAIL x_open_wrcnt got=%0d want=2", wrcnt); end
    data = 8'h77; eop = 1'b1; abort = 1'b1; step();
    total++; if (wrcnt !== 5'd1) begin bad++; $display("FAIL x_abort_wrcnt got=%0d want=1", wrcnt); end
    total++; if (rdcnt !== 5'd1) begin bad++; $display("FAIL x_abort_rdcnt got=%0d want=1", rdcnt); end
    idle(); step();
    total++; if (q !== 8'h55)    begin bad++; $display("FAIL x_head_q got=%h want=55", q); end
    we = 1'b1; data = 8'h99; re = 1'b1; step();
    total++; if (wrcnt !== 5'd1) begin bad++; $display("FAIL x_pair_wrcnt got=%0d want=1", wrcnt); end
    total++; if (rdcnt !== 5'd0) begin bad++; $display("FAIL x_pair_rdcnt got=%0d want=0", rdcnt); end
    total++; if (empty !== 1'b1) begin bad++; $display("FAIL x_pair_empty got=%b want=1", empty); end
    idle(); abort = 1'b1; step(); idle(); step(); step();
    total++; if (wrcnt !== 5'd0) begin bad++; $display("FAIL x_clean_wrcnt got=%0d want=0", wrcnt); end
    total++; if (dvld !== 1'b0)  begin bad++; $display("FAIL x_clean_dvld got=%b want=0", dvld); end
    we = 1'b1;
    for (int i = 0; i < 16; i++) begin
      data = 8'hC0 + 8'(i); eop = (i == 15); step();
    end
    idle(); step(); step();
    total++; if (full !== 1'b1)  begin bad++; $display("FAIL x_full got=%b want=1", full); end
    we = 1'b1; data = 8'hEE; eop = 1'b1; re = 1'b1; step();
    total++; if (wrcnt !== 5'd15) begin bad++; $display("FAIL x_fullpop_wrcnt got=%0d want=15", wrcnt); end
    total++; if (rdcnt !== 5'd15) begin bad++; $display("FAIL x_fullpop_rdcnt got=%0d want=15", rdcnt); end
    total++; if (q !== 8'hC1)     begin bad++; $display("FAIL x_fullpop_q got=%h want=c1", q); end
    idle(); re = 1'b1;
    for (int i = 1; i < 16; i++) begin
      total++; if (q !== 8'hC0 + 8'(i)) begin bad++; $display("FAIL x_drain_q[%0d] got=%h want=%h", i, q, 8'hC0 + 8'(i)); end
      step();
    end
    total++; if (empty !== 1'b1) begin bad++; $display("FAIL x_drain_empty got=%b want=1", empty); end
    total++; if (wrcnt !== 5'd0) begin bad++; $display("FAIL x_drain_wrcnt got=%0d want=0", wrcnt); end
    idle();
  endtask

  task automatic test_mid_reset();
    idle(); we = 1'b1; eop = 1'b1; data = 8'h42; step();
    eop = 1'b0; data = 8'h43; step(); step();
    idle(); step();
    total++; if (dvld !== 1'b1) begin bad++; $display("FAIL m_pre_dvld got=%b want=1", dvld); end
    we = 1'b1; data = 8'h44; reset = 1'b1; step();
    reset = 1'b0; idle();
    total++; if (wrcnt !== 5'd0) begin bad++; $display("FAIL m_wrcnt got=%0d want=0", wrcnt); end
    total++; if (rdcnt !== 5'd0) begin bad++; $display("FAIL m_rdcnt got=%0d want=0", rdcnt); end
    total++; if (q !== 8'h00)    begin bad++; $display("FAIL m_q got=%h want=00", q); end
    step(); step(); step();
    total++; if (dvld !== 1'b0)  begin bad++; $display("FAIL m_late_dvld got=%b want=0", dvld); end
  endtask

`ifdef PAYLOAD_FIFO_ERR_FLAGS_EN
  task automatic test_err_flags();
    idle();
    total++; if (underflow !== 1'b0) begin bad++; $display("FAIL e_init_uf got=%b want=0", underflow); end
    total++; if (overflow !== 1'b0)  begin bad++; $display("FAIL e_init_of got=%b want=0", overflow); end
    re = 1'b1; step(); re = 1'b0;
    total++; if (underflow !== 1'b1) begin bad++; $display("FAIL e_uf got=%b want=1", underflow); end
    we = 1'b1;
    for (int i = 0; i < 16; i++) begin
      data = 8'(i); eop = (i == 15); step();
    end
    total++; if (overflow !== 1'b0)  begin bad++; $display("FAIL e_pre_of got=%b want=0", overflow); end
    data = 8'hEE; step();
    total++; if (overflow !== 1'b1)  begin bad++; $display("FAIL e_of got=%b want=1", overflow); end
    idle(); re = 1'b1; step(); step(); idle();
    total++; if (overflow !== 1'b1)  begin bad++; $display("FAIL e_hold_of got=%b want=1", overflow); end
    total++; if (underflow !== 1'b1) begin bad++; $display("FAIL e_hold_uf got=%b want=1", underflow); end
    reset = 1'b1; step(); reset = 1'b0;
    total++; if (overflow !== 1'b0)  begin bad++; $display("FAIL e_rst_of got=%b want=0", overflow); end
    total++; if (underflow !== 1'b0) begin bad++; $display("FAIL e_rst_uf got=%b want=0", underflow); end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    idle(); reset = 1'b1;
    test_reset();
    test_commit();
    test_abort();
    test_full();
    test_back_to_back();
    test_same_cycle();
    test_mid_reset();
`ifdef PAYLOAD_FIFO_ERR_FLAGS_EN
    test_err_flags();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
